// File: rtl/regfile_multi.sv
// Parametrised 1W/2R register file with write-first bypass and a post-reset clear sequencer.
// Optional hardwired-zero register 0 is enabled by defining ZERO_REG_EN.
module regfile_multi #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_1_i,
    input  logic [ADDR_W-1:0] rd_addr_1_i,
    output logic [DATA_W-1:0] rd_data_1_o,
    input  logic              rd_en_2_i,
    input  logic [ADDR_W-1:0] rd_addr_2_i,
    output logic [DATA_W-1:0] rd_data_2_o,
    output logic              busy_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LastIdx = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PtrOne  = 1;

    typedef enum logic {
        StClear,
        StReady
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   rd_data_1_q, rd_data_1_d;
    logic [DATA_W-1:0]   rd_data_2_q, rd_data_2_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                wr_eff;
    logic [DATA_W-1:0]   rd_val_1, rd_val_2;

`ifdef ZERO_REG_EN
    // Register 0 is read-only zero: drop writes aimed at it.
    assign wr_eff = wr_en_i && (wr_addr_i != '0);
`else
    assign wr_eff = wr_en_i;
`endif

    // Write-first: a same-cycle write to the read address wins over the array.
    always_comb begin
        rd_val_1 = mem_q[rd_addr_1_i];
        rd_val_2 = mem_q[rd_addr_2_i];
        if (wr_eff && (wr_addr_i == rd_addr_1_i)) begin
            rd_val_1 = wr_data_i;
        end
        if (wr_eff && (wr_addr_i == rd_addr_2_i)) begin
            rd_val_2 = wr_data_i;
        end
`ifdef ZERO_REG_EN
        if (rd_addr_1_i == '0) begin
            rd_val_1 = '0;
        end
        if (rd_addr_2_i == '0) begin
            rd_val_2 = '0;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        rd_data_1_d = rd_data_1_q;
        rd_data_2_d = rd_data_2_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_addr_i;
        mem_wdata   = wr_data_i;
        unique case (state_q)
            StClear: begin
                mem_we      = 1'b1;
                mem_waddr   = clr_ptr_q;
                mem_wdata   = '0;
                rd_data_1_d = '0;
                rd_data_2_d = '0;
                if (clr_ptr_q == LastIdx) begin
                    state_d   = StReady;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + PtrOne;
                end
            end
            StReady: begin
                mem_we = wr_eff;
                if (rd_en_1_i) begin
                    rd_data_1_d = rd_val_1;
                end
                if (rd_en_2_i) begin
                    rd_data_2_d = rd_val_2;
                end
            end
            default: begin
                state_d   = StClear;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StClear;
            clr_ptr_q   <= '0;
            rd_data_1_q <= '0;
            rd_data_2_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            rd_data_1_q <= rd_data_1_d;
            rd_data_2_q <= rd_data_2_d;
        end
    end

    // Array has no reset; the clear sequencer zeroes it synchronously.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_data_1_o = rd_data_1_q;
    assign rd_data_2_o = rd_data_2_q;
    assign busy_o      = (state_q == StClear);

endmodule

// File: tb/tb_regfile_multi.sv
// Self-checking bench for regfile_multi: reference model plus scoreboard queue of expected reads.
// Define ZERO_REG_EN for both bench and RTL to check the hardwired-zero build.
module tb_regfile_multi;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_en_1 = 1'b0;
    logic [ADDR_W-1:0] rd_addr_1 = '0;
    logic [DATA_W-1:0] rd_data_1;
    logic              rd_en_2 = 1'b0;
    logic [ADDR_W-1:0] rd_addr_2 = '0;
    logic [DATA_W-1:0] rd_data_2;
    logic              busy;

    regfile_multi #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_en_1_i  (rd_en_1),
        .rd_addr_1_i(rd_addr_1),
        .rd_data_1_o(rd_data_1),
        .rd_en_2_i  (rd_en_2),
        .rd_addr_2_i(rd_addr_2),
        .rd_data_2_o(rd_data_2),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] hold_1, hold_2;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic we, input logic [4:0] wa,
                                               input logic [31:0] wd, input logic [4:0] ra);
        logic [31:0] v;
        v = (we && wa == ra) ? wd : model_mem[ra];
`ifdef ZERO_REG_EN
        if (ra == 5'd0) v = 32'h0;
`endif
        return v;
    endfunction

    // One READY-state cycle: push expectations, clock, then drain and compare.
    task automatic do_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic re1, input logic [4:0] ra1,
                            input logic re2, input logic [4:0] ra2);
        exp_t e;
        logic we_eff;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en_1 = re1; rd_addr_1 = ra1; rd_en_2 = re2; rd_addr_2 = ra2;
        we_eff = we;
`ifdef ZERO_REG_EN
        if (wa == 5'd0) we_eff = 1'b0;
`endif
        if (re1) hold_1 = model_read(we_eff, wa, wd, ra1);
        if (re2) hold_2 = model_read(we_eff, wa, wd, ra2);
        e.port = 1; e.val = hold_1; sb_q.push_back(e);
        e.port = 2; e.val = hold_2; sb_q.push_back(e);
        if (we_eff) model_mem[wa] = wd;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.port == 1) check_eq("rd_data_1", rd_data_1, e.val);
            else             check_eq("rd_data_2", rd_data_2, e.val);
        end
        wr_en = 1'b0; rd_en_1 = 1'b0; rd_en_2 = 1'b0;
    endtask

    // Count edges until busy drops; requests driven meanwhile must be ignored.
    task automatic wait_clear(output int n);
        n = 0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hAAAA_5555;
        rd_en_1 = 1'b1; rd_addr_1 = 5'd5; rd_en_2 = 1'b1; rd_addr_2 = 5'd5;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        wr_en = 1'b0; rd_en_1 = 1'b0; rd_en_2 = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("reset_busy", {31'h0, busy}, 32'h1);
        check_eq("reset_rd1", rd_data_1, 32'h0);
        check_eq("reset_rd2", rd_data_2, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        hold_1 = 32'h0;
        hold_2 = 32'h0;
    endtask

    initial begin
        int n;
        int unsigned r;

        // Reset and full clear, with requests ignored while busy
        apply_reset();
        wait_clear(n);
        check_eq("clear_cycles", n, 32'd32);
        check_eq("clear_rd1", rd_data_1, 32'h0);
        check_eq("clear_rd2", rd_data_2, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(DEPTH - 1 - i));
        end

        // Basic write/read and hold
        do_cycle(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 5'd9, 32'h0BAD_0000 + i, 1'b0, 5'd7, 1'b0, 5'd9);
        end

        // Bypass on port 2, then on both ports
        do_cycle(1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 1'b1, 5'd3);
        do_cycle(1'b1, 5'd4, 32'hCAFE_F00D, 1'b1, 5'd4, 1'b1, 5'd4);

        // Register 0 behaviour (build-dependent expectation)
        do_cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0);
`ifdef ZERO_REG_EN
        check_eq("zero_reg", rd_data_1, 32'h0);
`else
        check_eq("zero_reg", rd_data_1, 32'hFFFF_FFFF);
`endif

        // Dual read and swap
        do_cycle(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0);
        do_cycle(1'b1, 5'd2, 32'h3, 1'b0, 5'd0, 1'b0, 5'd0);
        do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2);
        do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b1, 5'd1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            do_cycle(r[0], 5'(r[5:1]), $urandom, r[6], 5'(r[11:7]), r[12], 5'(r[17:13]));
        end

        // Reset mid-clear restarts the full sequence
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
        end
        #1;
        rst = 1'b1;
        #1;
        check_eq("midclr_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        wait_clear(n);
        check_eq("midclr_cycles", n, 32'd32);
        do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd7);

        // Reset from READY after traffic wipes the array
        do_cycle(1'b1, 5'd12, 32'h5A5A_A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
        apply_reset();
        wait_clear(n);
        check_eq("ready_rst_cycles", n, 32'd32);
        do_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b1, 5'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
